// File: rtl/drcp_lsu_apb_bridge.sv
// LSU-to-APB4 bridge: one APB transfer per LSU request, AMOs rejected locally,
// optional ACCESS-phase watchdog turns a hung slave into an access fault.
module drcp_lsu_apb_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter bit          TIMEOUT_EN     = 1'b1,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  lsu_req_i,
   input  logic                  lsu_we_i,
   input  logic [31:0]           lsu_addr_i,
   input  logic [31:0]           lsu_wdata_i,
   input  logic [3:0]            lsu_amo_i,
   input  logic [3:0]            lsu_strb_i,
   output logic                  lsu_valid_o,
   output logic                  lsu_error_o,
   output logic [31:0]           lsu_rdata_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [31:0]           pwdata_o,
   output logic [3:0]            pstrb_o,
   output logic [2:0]            pprot_o,
   input  logic                  pready_i,
   input  logic [31:0]           prdata_i,
   input  logic                  pslverr_i
);

   localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [31:0]           pwdata_q, pwdata_d;
   logic [3:0]            pstrb_q, pstrb_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;
   logic [31:0]           rdata_q, rdata_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      // Response registers are loaded only on entry to RESP, so they pulse for one cycle.
      valid_d   = 1'b0;
      error_d   = 1'b0;
      rdata_d   = '0;

      case (state_q)
         StIdle: begin
            cnt_d     = '0;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (lsu_req_i) begin
               if (lsu_amo_i != 4'h0) begin
                  valid_d = 1'b1;
                  error_d = 1'b1;
                  state_d = StResp;
               end else begin
                  paddr_d  = lsu_addr_i[ADDR_WIDTH-1:0];
                  pwrite_d = lsu_we_i;
                  pwdata_d = lsu_wdata_i;
                  pstrb_d  = lsu_we_i ? lsu_strb_i : 4'h0;
                  psel_d   = 1'b1;
                  state_d  = StSetup;
               end
            end
         end
         StSetup: begin
            cnt_d     = '0;
            penable_d = 1'b1;
            state_d   = StAccess;
         end
         StAccess: begin
            if (pready_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               valid_d   = 1'b1;
               error_d   = pslverr_i;
               rdata_d   = (!pwrite_q && !pslverr_i) ? prdata_i : 32'h0;
               state_d   = StResp;
            end else begin
               if (cnt_q != {CntWidth{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (TIMEOUT_EN && (cnt_q == CntLast)) begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  valid_d   = 1'b1;
                  error_d   = 1'b1;
                  state_d   = StResp;
               end
            end
         end
         StResp: begin
            // A still-high request here is deliberately ignored.
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         valid_q   <= valid_d;
         error_q   <= error_d;
         rdata_q   <= rdata_d;
      end
   end

   assign paddr_o     = paddr_q;
   assign psel_o      = psel_q;
   assign penable_o   = penable_q;
   assign pwrite_o    = pwrite_q;
   assign pwdata_o    = pwdata_q;
   assign pstrb_o     = pstrb_q;
   assign pprot_o     = 3'b000;
   assign lsu_valid_o = valid_q;
   assign lsu_error_o = error_q;
   assign lsu_rdata_o = rdata_q;

endmodule

// File: tb/tb_drcp_lsu_apb_bridge.sv
// Bench for drcp_lsu_apb_bridge: directed scenarios plus random traffic against
// a latency/result model and a small APB slave with programmable wait states.
module tb_drcp_lsu_apb_bridge;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lsu_req, lsu_we;
   logic [31:0] lsu_addr, lsu_wdata;
   logic [3:0]  lsu_amo, lsu_strb;
   logic        lsu_valid, lsu_error;
   logic [31:0] lsu_rdata;
   logic [31:0] paddr;
   logic        psel, penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic        pready;
   logic [31:0] prdata;
   logic        pslverr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   drcp_lsu_apb_bridge #(
      .ADDR_WIDTH     (32),
      .TIMEOUT_EN     (1'b1),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .lsu_req_i   (lsu_req),
      .lsu_we_i    (lsu_we),
      .lsu_addr_i  (lsu_addr),
      .lsu_wdata_i (lsu_wdata),
      .lsu_amo_i   (lsu_amo),
      .lsu_strb_i  (lsu_strb),
      .lsu_valid_o (lsu_valid),
      .lsu_error_o (lsu_error),
      .lsu_rdata_o (lsu_rdata),
      .paddr_o     (paddr),
      .psel_o      (psel),
      .penable_o   (penable),
      .pwrite_o    (pwrite),
      .pwdata_o    (pwdata),
      .pstrb_o     (pstrb),
      .pprot_o     (pprot),
      .pready_i    (pready),
      .prdata_i    (prdata),
      .pslverr_i   (pslverr)
   );

   // One LSU request; waits >= TO means the slave never answers.
   task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] amo,
                          input logic [3:0] strb, input int waits,
                          input logic [31:0] slv_rdata, input logic slv_err);
      int          exp_lat, exp_acc, exp_setup;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          lat, acc, setups;
      bit          attr_bad, idle_bad;
      logic        got_err;
      logic [31:0] got_rdata;

      if (amo != 4'h0) begin
         exp_lat = 1; exp_acc = 0; exp_setup = 0; exp_err = 1'b1; exp_rdata = 32'h0;
      end else if (waits >= int'(TO)) begin
         exp_lat = 2 + int'(TO); exp_acc = int'(TO); exp_setup = 1;
         exp_err = 1'b1; exp_rdata = 32'h0;
      end else begin
         exp_lat = 3 + waits; exp_acc = waits + 1; exp_setup = 1; exp_err = slv_err;
         exp_rdata = (!we && !slv_err) ? slv_rdata : 32'h0;
      end

      @(posedge clk); #1;
      lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata;
      lsu_amo = amo; lsu_strb = strb;
      lat = -1; acc = 0; setups = 0; attr_bad = 0; idle_bad = 0;
      got_err = 1'b0; got_rdata = 32'h0;

      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (psel) begin
            if (paddr !== addr || pwrite !== we || pwdata !== wdata ||
                pstrb !== (we ? strb : 4'h0) || pprot !== 3'b000) attr_bad = 1;
            if (penable) begin
               pready  = (acc == waits);
               prdata  = pready ? slv_rdata : $urandom;
               pslverr = pready ? slv_err : 1'($urandom);
               acc++;
            end else begin
               setups++;
               pready = 1'b0;
            end
         end else begin
            if (penable) attr_bad = 1;
            pready = 1'b0;
         end
         if (lsu_valid) begin
            lat = k; got_err = lsu_error; got_rdata = lsu_rdata;
            break;
         end else if (lsu_error !== 1'b0 || lsu_rdata !== 32'h0) begin
            idle_bad = 1;
         end
      end

      checks++;
      if (lat !== exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      end
      checks++;
      if (got_err !== exp_err) begin
         failures++;
         $display("FAIL %s error: got %0b required %0b", name, got_err, exp_err);
      end
      checks++;
      if (got_rdata !== exp_rdata) begin
         failures++;
         $display("FAIL %s rdata: got %08h required %08h", name, got_rdata, exp_rdata);
      end
      checks++;
      if (acc !== exp_acc || setups !== exp_setup) begin
         failures++;
         $display("FAIL %s apb phases: got setup=%0d access=%0d required setup=%0d access=%0d",
                  name, setups, acc, exp_setup, exp_acc);
      end
      checks++;
      if (attr_bad || idle_bad) begin
         failures++;
         $display("FAIL %s signal stability: got attr_bad=%0b idle_bad=%0b required 0 0",
                  name, attr_bad, idle_bad);
      end

      // Request stays high through RESP and must not be re-sampled.
      @(posedge clk); #1;
      lsu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (lsu_valid !== 1'b0 || psel !== 1'b0) begin
         failures++;
         $display("FAIL %s after response: got valid=%0b psel=%0b required 0 0",
                  name, lsu_valid, psel);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
      lsu_amo = '0; lsu_strb = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({lsu_valid, lsu_error, lsu_rdata, paddr, psel, penable, pwrite, pwdata, pstrb,
           pprot} !== '0) begin
         failures++;
         $display("FAIL reset outputs: got valid=%0b psel=%0b penable=%0b paddr=%08h required all 0",
                  lsu_valid, psel, penable, paddr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      run_txn("load", 1'b0, 32'h2000_0010, 32'h0, 4'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0);
   endtask

   task automatic test_store_wait();
      run_txn("store_wait", 1'b1, 32'h4000_0004, 32'h1234_5678, 4'h0, 4'b0011, 3,
              32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_slverr();
      run_txn("slverr", 1'b0, 32'h2000_0100, 32'h0, 4'h0, 4'h0, 1, 32'hCAFE_F00D, 1'b1);
   endtask

   task automatic test_timeout();
      run_txn("timeout", 1'b0, 32'h2000_0200, 32'h0, 4'h0, 4'h0, 100, 32'h1111_1111, 1'b0);
      run_txn("after_timeout", 1'b0, 32'h2000_0204, 32'h0, 4'h0, 4'h0, 0, 32'h5555_AAAA,
              1'b0);
   endtask

   task automatic test_amo();
      run_txn("amo", 1'b1, 32'h2000_0300, 32'h9999_9999, 4'h2, 4'hF, 0, 32'h0, 1'b0);
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      bit pulse = 0;
      @(posedge clk); #1;
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h4000_0040; lsu_wdata = 32'hA5A5_5A5A;
      lsu_amo = 4'h0; lsu_strb = 4'hF;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         pready = 1'b0;
         if (psel && penable) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL reset_mid reach access: got no ACCESS phase required one");
      end
      rst_n = 1'b0; lsu_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || lsu_valid !== 1'b0 || pstrb !== 4'h0) begin
         failures++;
         $display("FAIL reset_mid outputs: got psel=%0b penable=%0b valid=%0b pstrb=%h required 0",
                  psel, penable, lsu_valid, pstrb);
      end
      repeat (4) begin
         @(negedge clk);
         if (lsu_valid || psel) pulse = 1;
      end
      checks++;
      if (pulse) begin
         failures++;
         $display("FAIL reset_mid abandoned: got valid/psel activity required none");
      end
      run_txn("after_reset", 1'b0, 32'h2000_0010, 32'h0, 4'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         logic [3:0] amo;
         amo = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         run_txn($sformatf("random%0d", i), 1'($urandom), $urandom, $urandom, amo,
                 4'($urandom), int'($urandom_range(0, 5)), $urandom,
                 ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_wait();
      test_slverr();
      test_timeout();
      test_amo();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
